// File: rtl/adder1_accum_ctrl_if.sv
// Command and result streams between a requester and the adder1 accumulator controller.
interface adder1_accum_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_ovf;

  // Requester side: issues commands, consumes results.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_sum, res_carry, res_ovf
  );

  // Controller side: accepts commands, produces results.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_sum, res_carry, res_ovf
  );
endinterface

// File: rtl/adder1_accum_ctrl.sv
// Sequential wrapper around the combinational adder1: one stage register drives the
// adder operands, the returned sum is flagged, accumulated and queued in a result FIFO.
module adder1_accum_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  adder1_accum_ctrl_if.slave bus,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  input  logic [WIDTH-1:0] adder_sum,
  output logic [WIDTH-1:0] acc_q,
  output logic             sticky_carry,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_ACC   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FC_W  = $clog2(DEPTH + 1);
  localparam logic [FC_W:0] DEPTH_OCC = (FC_W + 1)'(DEPTH);

  // Unsigned carry-out recovered from a wrapped sum.
  function automatic logic calc_carry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] s);
    return (s < a);
  endfunction

  // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
  function automatic logic calc_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic             stage_valid_r;
  logic [1:0]       stage_op_r;
  logic [WIDTH-1:0] stage_a_r;
  logic [WIDTH-1:0] stage_b_r;

  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic             carry_s;
  logic             ovf_s;
  logic [WIDTH-1:0] push_sum_s;
  logic             push_carry_s;
  logic             push_ovf_s;

  logic [WIDTH-1:0] sum_mem_r   [DEPTH];
  logic             carry_mem_r [DEPTH];
  logic             ovf_mem_r   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [FC_W-1:0]  fifo_count_r;
  logic [FC_W:0]    occ_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             res_valid_s;

  // Stage occupancy counts against FIFO space so a staged op always has a slot.
  assign occ_s         = {1'b0, fifo_count_r} + (FC_W + 1)'(stage_valid_r);
  assign bus.cmd_ready = (occ_s < DEPTH_OCC);
  assign accept_s      = bus.cmd_valid && bus.cmd_ready;
  assign push_s        = stage_valid_r;
  assign res_valid_s   = (fifo_count_r != {FC_W{1'b0}});
  assign pop_s         = res_valid_s && bus.res_ready;

  assign bus.res_valid = res_valid_s;
  assign bus.res_sum   = sum_mem_r[rd_ptr_r];
  assign bus.res_carry = carry_mem_r[rd_ptr_r];
  assign bus.res_ovf   = ovf_mem_r[rd_ptr_r];

  assign adder_a = op_a_s;
  assign adder_b = op_b_s;
  assign carry_s = calc_carry(op_a_s, adder_sum);
  assign ovf_s   = calc_ovf(op_a_s, op_b_s, adder_sum);

  // Stage register: latch an accepted command, otherwise go idle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stage_valid_r <= 1'b0;
      stage_op_r    <= OP_ADD;
      stage_a_r     <= {WIDTH{1'b0}};
      stage_b_r     <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      stage_valid_r <= 1'b1;
      stage_op_r    <= bus.cmd_op;
      stage_a_r     <= bus.cmd_a;
      stage_b_r     <= bus.cmd_b;
    end else begin
      stage_valid_r <= 1'b0;
    end
  end

  // Operand mux; ACC reads acc_q here so back-to-back accumulates chain.
  always_comb begin
    op_a_s = {WIDTH{1'b0}};
    op_b_s = {WIDTH{1'b0}};
    if (stage_valid_r) begin
      case (stage_op_r)
        OP_ADD:  begin op_a_s = stage_a_r; op_b_s = stage_b_r;      end
        OP_ACC:  begin op_a_s = acc_q;     op_b_s = stage_b_r;      end
        OP_LOAD: begin op_a_s = stage_a_r; op_b_s = {WIDTH{1'b0}};  end
        default: begin op_a_s = {WIDTH{1'b0}}; op_b_s = {WIDTH{1'b0}}; end
      endcase
    end else begin
      op_a_s = {WIDTH{1'b0}};
      op_b_s = {WIDTH{1'b0}};
    end
  end

  // Result entry written into the FIFO; CLEAR pushes an all-zero record.
  always_comb begin
    push_sum_s   = adder_sum;
    push_carry_s = carry_s;
    push_ovf_s   = ovf_s;
    if (stage_op_r == OP_CLEAR) begin
      push_sum_s   = {WIDTH{1'b0}};
      push_carry_s = 1'b0;
      push_ovf_s   = 1'b0;
    end else begin
      push_sum_s   = adder_sum;
      push_carry_s = carry_s;
      push_ovf_s   = ovf_s;
    end
  end

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        sum_mem_r[i]   <= {WIDTH{1'b0}};
        carry_mem_r[i] <= 1'b0;
        ovf_mem_r[i]   <= 1'b0;
      end
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {FC_W{1'b0}};
    end else begin
      if (push_s) begin
        sum_mem_r[wr_ptr_r]   <= push_sum_s;
        carry_mem_r[wr_ptr_r] <= push_carry_s;
        ovf_mem_r[wr_ptr_r]   <= push_ovf_s;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + FC_W'(1'b1);
        2'b01:   fifo_count_r <= fifo_count_r - FC_W'(1'b1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Accumulator, sticky carry and completion counter update on stage completion.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      acc_q        <= {WIDTH{1'b0}};
      sticky_carry <= 1'b0;
      op_count     <= {CNT_W{1'b0}};
    end else if (stage_valid_r) begin
      case (stage_op_r)
        OP_ACC, OP_LOAD: acc_q <= adder_sum;
        OP_CLEAR:        acc_q <= {WIDTH{1'b0}};
        default:         acc_q <= acc_q;
      endcase
      if (stage_op_r == OP_CLEAR) begin
        sticky_carry <= 1'b0;
      end else begin
        sticky_carry <= sticky_carry | carry_s;
      end
      op_count <= op_count + CNT_W'(1'b1);
    end
  end

endmodule

// File: doc/adder1_accum_ctrl.md
Name: adder1_accum_ctrl

Overview:
- Sequential front/back end for the combinational 8-bit `adder1` prefix adder.
- Accepts operation commands over a valid/ready stream and registers operands onto the adder inputs.
- Captures the adder's `sum` one cycle later and derives carry/overflow flags, since the adder has no carry-out.
- Maintains an accumulator and buffers results in a small FIFO towards the downstream consumer (user-project logic-analyzer/Wishbone readout).

Parameters:
- WIDTH, 8, operand/sum width; must equal the adder width.
- DEPTH, 4, result FIFO entries (power of two, >=2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- wb_clk_i  input  1  sole clock
- wb_rst_i  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  input  2  00 ADD, 01 ACC, 10 LOAD, 11 CLEAR
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- adder_a  output  WIDTH  drives adder a_in
- adder_b  output  WIDTH  drives adder b_in
- adder_sum  input  WIDTH  from adder sum (combinational return)
- res_valid  output  1  FIFO head valid
- res_ready  input  1  consumer pop
- res_sum  output  WIDTH  head result
- res_carry  output  1  head unsigned carry-out
- res_ovf  output  1  head signed overflow
- acc_q  output  WIDTH  current accumulator
- sticky_carry  output  1  OR of all carries since reset/CLEAR
- op_count  output  CNT_W  completed operations, wraps

Behaviour:

Reset (wb_rst_i=1 at a clock edge):
- Stage register, FIFO pointers/count, acc_q, sticky_carry and op_count are cleared.
- After reset: res_valid=0, cmd_ready=1, adder_a=adder_b=0.
- Reset mid-operation drops in-flight and buffered results; no partial output appears.

Pipeline:
- Accept cycle N: the cmd fields are latched into the stage register (stage_valid=1).
- Stage cycle N+1:
  - Stage drives adder_a/adder_b.
  - At the end of N+1 the result is written to the FIFO and acc/sticky/count update.
- res_valid rises at N+2 when the FIFO was empty. Latency is 2 cycles accept-to-valid.

Operand mux (from stage register; adder_a/adder_b are registered-source, glitch-free):
- ADD: a=cmd_a, b=cmd_b; acc unchanged.
- ACC: a=acc_q, b=cmd_b; acc_q<=adder_sum.
- LOAD: a=cmd_a, b=0; acc_q<=adder_sum (=cmd_a).
- CLEAR: a=0, b=0; acc_q<=0, sticky_carry<=0, result pushed as 0 with flags 0.

ACC hazard rule:
- The ACC A-operand is read from acc_q in the stage cycle, not at accept.
- Back-to-back ACC commands therefore chain correctly with no bubbles.

Flags, computed from the stage operands and adder_sum:
- carry = (adder_sum < adder_a) unsigned compare.
- ovf = (adder_a[W-1]==adder_b[W-1]) && (adder_sum[W-1]!=adder_a[W-1]).
- Sum wraps modulo 2^WIDTH.

Status registers:
- sticky_carry |= carry for every non-CLEAR op.
- op_count increments once per stage completion, including CLEAR. It wraps from 2^CNT_W-1 to 0.

Flow control:
- cmd_ready = (fifo_count + stage_valid) < DEPTH. It does not depend on res_ready combinationally.
- With DEPTH>=3 and res_ready held high, throughput is one op per cycle.

FIFO:
- Pop when res_valid&&res_ready.
- Simultaneous push and pop keeps the count unchanged.
- Pointers wrap modulo DEPTH.
- Head outputs stay stable while res_valid&&!res_ready.
- Push into a full FIFO cannot occur by construction; the assertion is checked in verification.

Test Plan:
- Reset, then ADD a=0x0F b=0x01 -> res_valid at accept+2; sum=0x10, carry=0, ovf=0; op_count=1, acc_q=0.
- ADD a=0xFF b=0x02 -> sum=0x01, carry=1, ovf=0, sticky_carry=1. Then CLEAR -> sum=0x00, flags 0, sticky_carry=0, acc_q=0.
- ADD a=0x7F b=0x01 -> sum=0x80, ovf=1, carry=0. ADD a=0x80 b=0x80 -> sum=0x00, ovf=1, carry=1.
- LOAD a=0x05, then back-to-back ACC b=0x03, b=0x03, b=0xFA with res_ready=1 -> results 0x05, 0x08, 0x0B, 0x05 (carry=1) on consecutive cycles; final acc_q=0x05.
- res_ready=0, issue 6 ADDs -> cmd_ready drops after 4 accepts (3 FIFO + 1 stage, then FIFO full at 4). Raise res_ready -> all results drain in order, none lost or duplicated.
- Assert wb_rst_i for one cycle with 2 results buffered and 1 in stage -> next cycle res_valid=0, op_count=0, acc_q=0, cmd_ready=1. A following ADD 0x01+0x01 returns 0x02.
